// File: rtl/ibex_instr_mem_responder.sv
// ibex_instr_mem_responder: memory-side responder for the Ibex instruction
// fetch bus (req/gnt/rvalid). It grants fetches, reads a synchronous
// single-port RAM and returns in-order responses a fixed RESP_LATENCY cycles
// after the grant. Up to NUM_OUTSTANDING requests can be in flight.
// Optional build macro: IBEX_IMEM_GNT_STALL_EN. When it is defined, an 8-bit
// LFSR inserts pseudo-random grant stalls so initiators can be stress tested.
module ibex_instr_mem_responder #(
  parameter int unsigned MEM_AW          = 14,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned NUM_OUTSTANDING = 2,
  parameter int unsigned RESP_LATENCY    = 2
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              instr_req_i,
  output logic              instr_gnt_o,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  output logic              instr_err_o,
  output logic              mem_en_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  localparam int unsigned CNT_W = $clog2(NUM_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1;
  localparam int unsigned AGE_W = $clog2(RESP_LATENCY + 1);

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(NUM_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_OUTSTANDING - 1);
  localparam logic [AGE_W-1:0] AGE_DONE  = AGE_W'(RESP_LATENCY);
  localparam logic [AGE_W-1:0] AGE_FIRST = AGE_W'(1);
  // Window size in bytes; 33 bits so a full 2^30-word window still fits.
  localparam logic [32:0]      WIN_BYTES = 33'd4 << MEM_AW;

  // Circular pointer advance that wraps for any entry count.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Response queue storage.
  logic              valid_q [NUM_OUTSTANDING];
  logic              valid_d [NUM_OUTSTANDING];
  logic [31:0]       data_q  [NUM_OUTSTANDING];
  logic [31:0]       data_d  [NUM_OUTSTANDING];
  logic              err_q   [NUM_OUTSTANDING];
  logic              err_d   [NUM_OUTSTANDING];
  logic [AGE_W-1:0]  age_q   [NUM_OUTSTANDING];
  logic [AGE_W-1:0]  age_d   [NUM_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [31:0]       offset_s;
  logic              in_range_s;
  logic              rvalid_s;
  logic              gnt_s;
  logic              stall_s;

`ifdef IBEX_IMEM_GNT_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR (taps 8,6,5,4) stepping only while a request is present.
  always_comb begin
    if (instr_req_i) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register, reseeded on reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall_s = lfsr_q[0];
`else
  assign stall_s = 1'b0;
`endif

  // Address decode, head status and the grant decision for this cycle.
  always_comb begin
    // Unsigned subtraction: addresses below the base wrap to huge offsets.
    offset_s   = instr_addr_i - BASE_ADDR;
    in_range_s = ({1'b0, offset_s} < WIN_BYTES);
    rvalid_s   = valid_q[rd_ptr_q] & (age_q[rd_ptr_q] == AGE_DONE);
    // A pop this cycle frees a slot, so a full queue can still accept.
    gnt_s      = ~arst_i & instr_req_i & ~stall_s &
                 ((count_q < MAX_CNT) | rvalid_s);
  end

  // Queue next state: ageing, RAM data capture, pop of the head, push.
  always_comb begin
    for (int i = 0; i < NUM_OUTSTANDING; i++) begin
      valid_d[i] = valid_q[i];
      err_d[i]   = err_q[i];
      if (valid_q[i] && (age_q[i] != AGE_DONE)) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end else begin
        age_d[i] = age_q[i];
      end
      // RAM data arrives the cycle after the grant, i.e. while age is 1.
      if (valid_q[i] && (age_q[i] == AGE_FIRST)) begin
        data_d[i] = err_q[i] ? 32'h0000_0000 : mem_rdata_i;
      end else begin
        data_d[i] = data_q[i];
      end
    end

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (rvalid_s) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Push after pop: on a full queue the pushed slot is the one just freed.
    if (gnt_s) begin
      valid_d[wr_ptr_q] = 1'b1;
      err_d[wr_ptr_q]   = ~in_range_s;
      age_d[wr_ptr_q]   = AGE_FIRST;
      data_d[wr_ptr_q]  = 32'h0000_0000;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({gnt_s, rvalid_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state registers; reset drops every outstanding request.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < NUM_OUTSTANDING; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= 32'h0000_0000;
        err_q[i]   <= 1'b0;
        age_q[i]   <= {AGE_W{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_OUTSTANDING; i++) begin
        valid_q[i] <= valid_d[i];
        data_q[i]  <= data_d[i];
        err_q[i]   <= err_d[i];
        age_q[i]   <= age_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign instr_gnt_o    = gnt_s;
  assign mem_en_o       = gnt_s & in_range_s;
  assign mem_addr_o     = offset_s[MEM_AW+1:2];
  assign instr_rvalid_o = rvalid_s;
  assign instr_rdata_o  = rvalid_s ? data_q[rd_ptr_q] : 32'h0000_0000;
  assign instr_err_o    = rvalid_s & err_q[rd_ptr_q];
  assign busy_o         = (count_q != {CNT_W{1'b0}});

endmodule
